// File: rtl/core_muldiv_iter.sv
// core_muldiv_iter: iterative RV32M/RV64M multiply/divide unit for the execute stage.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge. Ready here never depends combinationally on valid.
// The request side accepts only in IDLE. The result side presents a
// registered result in DONE.
//
// Ports:
//   i_clk, i_rst     clock (rising edge) and asynchronous active-high reset
//   i_valid/o_ready  request handshake; o_ready is high only in IDLE
//   i_funct3         0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   i_rs1, i_rs2     operands (multiplicand/dividend, multiplier/divisor)
//   i_rd             destination tag, returned on o_rd
//   i_flush          kills any in-flight operation; IDLE on the next edge
//   o_valid/i_ready  result handshake toward writeback
//   o_result, o_rd   registered result and tag
//   o_busy           high in CALC or DONE (EX stall)
//   dbg_state        current FSM state (0 IDLE, 1 CALC, 2 DONE)
module core_muldiv_iter #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic            o_busy,
  output logic [1:0]      dbg_state
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------------
  logic            req_div, req_s1, req_s2, req_sign1, req_sign2;
  logic            req_div0, req_ovf, req_fast, accept;
  logic [XLEN-1:0] req_mag1, req_mag2, req_fast_result;

  assign req_div   = i_funct3[2];
  // MULH and MULHSU treat rs1 as signed; MULH alone treats rs2 as signed.
  // DIV and REM (funct3[0] clear) treat both as signed.
  assign req_s1    = req_div ? !i_funct3[0]
                             : (i_funct3[1:0] == 2'b01 || i_funct3[1:0] == 2'b10);
  assign req_s2    = req_div ? !i_funct3[0] : (i_funct3[1:0] == 2'b01);
  assign req_sign1 = req_s1 & i_rs1[XLEN-1];
  assign req_sign2 = req_s2 & i_rs2[XLEN-1];
  assign req_mag1  = req_sign1 ? -i_rs1 : i_rs1;
  assign req_mag2  = req_sign2 ? -i_rs2 : i_rs2;

  assign req_div0  = req_div && (i_rs2 == '0);
  assign req_ovf   = req_div && !i_funct3[0] && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
  assign req_fast  = req_div0 || req_ovf;
  assign accept    = i_valid && (state == IDLE) && !i_flush;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    req_fast_result = '0;
    if (req_div0) req_fast_result = i_funct3[1] ? i_rs1 : '1;
    else          req_fast_result = i_funct3[1] ? '0    : i_rs1;
  end

  // ---------------------------------------------------------------------------
  // Latched operation
  //   multiply: op_operand = |rs1|, acc_lo = |rs2| (shifted out LSB first),
  //             acc_hi collects the upper product half.
  //   divide:   op_operand = |rs2|, acc_lo = |rs1| (shifted out MSB first,
  //             quotient bits shifted in), acc_hi is the partial remainder.
  // ---------------------------------------------------------------------------
  logic [2:0]      op_f3;
  logic            op_sign1, op_sign2;
  logic [XLEN-1:0] op_operand, acc_hi, acc_lo;
  logic [CW-1:0]   cnt;

  // One iteration: BITS_PER_CYCLE unrolled single-bit steps.
  logic [XLEN-1:0] hi_nx, lo_nx;
  logic [XLEN:0]   step_sum;

  always_comb begin
    hi_nx    = acc_hi;
    lo_nx    = acc_lo;
    step_sum = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (!op_f3[2]) begin
        step_sum = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, op_operand} : {(XLEN+1){1'b0}});
        lo_nx    = {step_sum[0], lo_nx[XLEN-1:1]};
        hi_nx    = step_sum[XLEN:1];
      end else begin
        // Partial remainder stays below the divisor, so the shifted value
        // fits in XLEN+1 bits and the restored value fits in XLEN bits.
        step_sum = {hi_nx, lo_nx[XLEN-1]};
        lo_nx    = {lo_nx[XLEN-2:0], 1'b0};
        if (step_sum >= {1'b0, op_operand}) begin
          step_sum = step_sum - {1'b0, op_operand};
          lo_nx[0] = 1'b1;
        end
        hi_nx = step_sum[XLEN-1:0];
      end
    end
  end

  // Sign correction applied to the final iteration's value on entry to DONE.
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_result;

  always_comb begin
    prod_raw    = {hi_nx, lo_nx};
    prod_fix    = (op_sign1 ^ op_sign2) ? -prod_raw : prod_raw;
    quo_fix     = (op_sign1 ^ op_sign2) ? -lo_nx : lo_nx;
    rem_fix     = op_sign1 ? -hi_nx : hi_nx;
    calc_result = '0;
    case (op_f3)
      3'd0:                calc_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    calc_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          calc_result = quo_fix;
      default:             calc_result = rem_fix;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM: next state (flush beats accept and the result handshake)
  always_comb begin
    state_nx = state;
    if (i_flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_valid) state_nx = req_fast ? DONE : CALC;
        CALC:    if (cnt == CNT_LAST) state_nx = DONE;
        DONE:    if (i_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // FSM: outputs, derived from registered state only
  always_comb begin
    o_ready   = (state == IDLE);
    o_busy    = (state != IDLE);
    o_valid   = (state == DONE);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_f3      <= '0;
      op_sign1   <= 1'b0;
      op_sign2   <= 1'b0;
      op_operand <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
      o_result   <= '0;
      o_rd       <= '0;
    end else if (accept) begin
      op_f3    <= i_funct3;
      op_sign1 <= req_sign1;
      op_sign2 <= req_sign2;
      acc_hi   <= '0;
      cnt      <= '0;
      o_rd     <= i_rd;
      if (req_div) begin
        op_operand <= req_mag2;
        acc_lo     <= req_mag1;
      end else begin
        op_operand <= req_mag1;
        acc_lo     <= req_mag2;
      end
      if (req_fast) o_result <= req_fast_result;
    end else if (state == CALC && !i_flush) begin
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_LAST) o_result <= calc_result;
    end
  end

endmodule
